// File: rtl/paddle_motion_ctrl.sv
// Pong paddle controller: synchronised buttons drive a ticked hold-to-accelerate motion FSM with edge clamping.
// y/speed/at_limit change on the tick cycle; disp_paddle_o is registered, one cycle after h_pos_i/v_pos_i.
module paddle_motion_ctrl #(
  parameter int SIDE        = 0,
  parameter int PADDLE_H    = 48,
  parameter int PADDLE_W    = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TICK_CYCLES = 2500000,
  parameter int MAX_SPEED   = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic        in_clk_i,
  input  logic        reset_ni,
  input  logic        push_up_i,
  input  logic        push_dn_i,
  input  logic [11:0] h_pos_i,
  input  logic [11:0] v_pos_i,
  output logic [8:0]  y_paddle_o,
  output logic [2:0]  speed_o,
  output logic        at_limit_o,
  output logic        disp_paddle_o
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_TICKS);
  localparam logic [2:0]    SPD_MAX   = 3'(MAX_SPEED);
  localparam logic [8:0]    Y_MAX     = 9'(SCREEN_H - PADDLE_H);
  localparam logic [8:0]    Y_RST     = 9'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [11:0]   X_LO      = 12'((SIDE != 0) ? (SCREEN_W - PADDLE_W) : 0);

  typedef enum logic [1:0] {IDLE, UP, DN} state_e;

  state_e          state_q, state_d, nxt_dir;
  logic [1:0]      up_sync_q, dn_sync_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      speed_q, speed_d;
  logic [8:0]      y_q, y_d;
  logic            at_limit_q, at_limit_d;
  logic            disp_q, disp_d;
  logic            up, dn, tick;
  logic signed [9:0] y_n, spd_s;
  logic [11:0]     row_off, col_off;

  assign up   = ~up_sync_q[1];
  assign dn   = ~dn_sync_q[1];
  assign tick = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    nxt_dir = IDLE;
    if (up && !dn)      nxt_dir = UP;
    else if (dn && !up) nxt_dir = DN;
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    hold_d  = hold_q;
    y_d     = y_q;
    y_n     = $signed({1'b0, y_q});
    spd_s   = '0;
    if (tick) begin
      state_d = nxt_dir;
      if (nxt_dir == IDLE || nxt_dir != state_q) begin
        speed_d = 3'd1;
        hold_d  = '0;
      end else if (hold_q + 1'b1 == HOLD_LAST) begin
        hold_d = '0;
        if (speed_q < SPD_MAX) speed_d = speed_q + 3'd1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
      // Motion uses the speed just updated on this tick.
      spd_s = $signed({7'b0, speed_d});
      if (nxt_dir == UP) begin
        y_n = $signed({1'b0, y_q}) - spd_s;
        y_d = (y_n < 0) ? 9'd0 : y_n[8:0];
      end else if (nxt_dir == DN) begin
        y_n = $signed({1'b0, y_q}) + spd_s;
        y_d = (y_n > $signed({1'b0, Y_MAX})) ? Y_MAX : y_n[8:0];
      end
    end
  end

  assign at_limit_d = (y_d == 9'd0) || (y_d == Y_MAX);

  // Offsets wrap to large values when below the window, so one compare per axis suffices.
  assign row_off = v_pos_i - {3'b0, y_q};
  assign col_off = h_pos_i - X_LO;
  assign disp_d  = (row_off < 12'(PADDLE_H)) && (v_pos_i < 12'(SCREEN_H)) &&
                   (col_off < 12'(PADDLE_W));

  always_ff @(posedge in_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      up_sync_q  <= 2'b11;
      dn_sync_q  <= 2'b11;
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      speed_q    <= 3'd1;
      hold_q     <= '0;
      y_q        <= Y_RST;
      at_limit_q <= 1'b0;
      disp_q     <= 1'b0;
    end else begin
      up_sync_q  <= {up_sync_q[0], push_up_i};
      dn_sync_q  <= {dn_sync_q[0], push_dn_i};
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      speed_q    <= speed_d;
      hold_q     <= hold_d;
      y_q        <= y_d;
      at_limit_q <= at_limit_d;
      disp_q     <= disp_d;
    end
  end

  assign y_paddle_o    = y_q;
  assign speed_o       = speed_q;
  assign at_limit_o    = at_limit_q;
  assign disp_paddle_o = disp_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Bench for paddle_motion_ctrl: left and right instances share stimulus and are compared every cycle
// against a tick-level behavioural model, plus directed motion, clamp, reversal, pixel and reset cases.
module tb_paddle_motion_ctrl;
  localparam int TC   = 4;
  localparam int MS   = 3;
  localparam int AT   = 2;
  localparam int YMAX = 432;
  localparam int YRST = 216;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pu = 1'b1;
  logic        pd = 1'b1;
  logic [11:0] h = 12'd320;
  logic [11:0] v = 12'd240;
  logic [8:0]  y0, y1;
  logic [2:0]  s0, s1;
  logic        a0, a1, d0, d1;

  always #5 clk = ~clk;

  paddle_motion_ctrl #(.SIDE(0), .TICK_CYCLES(TC), .MAX_SPEED(MS), .ACCEL_TICKS(AT)) u_left (
    .in_clk_i(clk), .reset_ni(rst_n), .push_up_i(pu), .push_dn_i(pd),
    .h_pos_i(h), .v_pos_i(v), .y_paddle_o(y0), .speed_o(s0),
    .at_limit_o(a0), .disp_paddle_o(d0));

  paddle_motion_ctrl #(.SIDE(1), .TICK_CYCLES(TC), .MAX_SPEED(MS), .ACCEL_TICKS(AT)) u_right (
    .in_clk_i(clk), .reset_ni(rst_n), .push_up_i(pu), .push_dn_i(pd),
    .h_pos_i(h), .v_pos_i(v), .y_paddle_o(y1), .speed_o(s1),
    .at_limit_o(a1), .disp_paddle_o(d1));

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: position/speed as plain integers, updated once per motion tick.
  int m_edges, m_ticks, m_dir, m_speed, m_hold, m_y, m_atl, m_d0, m_d1;
  bit m_u1, m_u2, m_n1, m_n2;

  function automatic int on_pad(input int side, input int hh, input int vv, input int yy);
    int xlo;
    xlo = (side != 0) ? 630 : 0;
    return (hh >= xlo && hh < xlo + 10 && vv >= yy && vv < yy + 48 && vv < 480) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_edges = 0; m_dir = 0; m_speed = 1; m_hold = 0; m_y = YRST; m_atl = 0;
    m_d0 = 0; m_d1 = 0; m_u1 = 1; m_u2 = 1; m_n1 = 1; m_n2 = 1;
  endtask

  task automatic model_step();
    bit eu, ed;
    int nd;
    eu = !m_u2;
    ed = !m_n2;
    m_u2 = m_u1; m_u1 = pu;
    m_n2 = m_n1; m_n1 = pd;
    m_d0 = on_pad(0, int'(h), int'(v), m_y);
    m_d1 = on_pad(1, int'(h), int'(v), m_y);
    m_edges++;
    if (m_edges % TC == 0) begin
      m_ticks++;
      nd = (eu && !ed) ? 1 : ((ed && !eu) ? 2 : 0);
      if (nd == 0 || nd != m_dir) begin
        m_speed = 1;
        m_hold  = 0;
      end else begin
        m_hold++;
        if (m_hold == AT) begin
          m_hold = 0;
          if (m_speed < MS) m_speed++;
        end
      end
      if (nd == 1) m_y = (m_y - m_speed < 0) ? 0 : m_y - m_speed;
      if (nd == 2) m_y = (m_y + m_speed > YMAX) ? YMAX : m_y + m_speed;
      m_dir = nd;
    end
    m_atl = (m_y == 0 || m_y == YMAX) ? 1 : 0;
  endtask

  initial begin
    m_ticks = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk_eq("y_left", int'(y0), m_y);
        chk_eq("y_right", int'(y1), m_y);
        chk_eq("speed_left", int'(s0), m_speed);
        chk_eq("speed_right", int'(s1), m_speed);
        chk_eq("at_limit_left", int'(a0), m_atl);
        chk_eq("at_limit_right", int'(a1), m_atl);
        chk_eq("disp_left", int'(d0), m_d0);
        chk_eq("disp_right", int'(d1), m_d1);
      end
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = m_ticks + n;
    guard = 0;
    while (m_ticks < target && guard < 8 * n + 8) begin
      @(negedge clk);
      guard++;
    end
    if (m_ticks < target) chk_eq("tick_timeout", m_ticks, target);
  endtask

  int t5_h[6]  = '{635, 629, 639, 639, 9, 10};
  int t5_v[6]  = '{216, 216, 263, 264, 240, 240};
  int t5_sd[6] = '{1, 1, 1, 1, 0, 0};
  int t5_ex[6] = '{1, 0, 1, 0, 1, 0};
  int t2_y[8]  = '{215, 214, 212, 210, 207, 204, 201, 198};
  int t2_s[8]  = '{1, 1, 2, 2, 3, 3, 3, 3};

  initial begin
    repeat (3) @(negedge clk);
    chk_eq("rst_y", int'(y0), YRST);
    chk_eq("rst_speed", int'(s0), 1);
    chk_eq("rst_at_limit", int'(a0), 0);
    chk_eq("rst_disp", int'(d1), 0);
    rst_n = 1'b1;
    chk_eq("rst_disp_left", int'(d0), 0);
    chk_en = 1'b1;

    repeat (40) @(negedge clk);
    chk_eq("idle_y", int'(y0), YRST);
    chk_eq("idle_speed", int'(s0), 1);
    chk_eq("idle_disp_off", int'(d0), 0);

    for (int i = 0; i < 6; i++) begin
      h = 12'(t5_h[i]);
      v = 12'(t5_v[i]);
      @(negedge clk);
      chk_eq($sformatf("pix_%0d", i), (t5_sd[i] != 0) ? int'(d1) : int'(d0), t5_ex[i]);
    end
    h = 12'd320;
    v = 12'd240;

    wait_ticks(1);
    pu = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(1);
      chk_eq($sformatf("up_y_%0d", i), int'(y0), t2_y[i]);
      chk_eq($sformatf("up_speed_%0d", i), int'(s0), t2_s[i]);
    end

    pu = 1'b1;
    pd = 1'b0;
    wait_ticks(1);
    chk_eq("rev_y", int'(y0), 199);
    chk_eq("rev_speed", int'(s0), 1);
    pu = 1'b0;
    wait_ticks(1);
    chk_eq("both_y", int'(y0), 199);
    chk_eq("both_speed", int'(s0), 1);
    wait_ticks(2);
    chk_eq("both_y_held", int'(y0), 199);

    pu = 1'b1;
    wait_ticks(100);
    chk_eq("clamp_y", int'(y0), YMAX);
    chk_eq("clamp_at_limit", int'(a0), 1);
    chk_eq("clamp_speed_kept", int'(s0), 3);
    pu = 1'b0;
    pd = 1'b1;
    wait_ticks(1);
    chk_eq("back_y1", int'(y0), 431);
    chk_eq("back_at_limit", int'(a0), 0);
    wait_ticks(1);
    chk_eq("back_y2", int'(y0), 430);
    pu = 1'b1;
    wait_ticks(1);
    chk_eq("rel_y", int'(y0), 430);
    pd = 1'b0;
    wait_ticks(1);
    chk_eq("dn_y1", int'(y0), 431);
    wait_ticks(1);
    chk_eq("dn_y2", int'(y0), 432);
    chk_eq("dn_at_limit", int'(a0), 1);
    wait_ticks(1);
    chk_eq("dn_y3", int'(y0), 432);
    chk_eq("dn_speed3", int'(s0), 2);
    wait_ticks(1);
    chk_eq("dn_y4", int'(y0), 432);

    for (int i = 0; i < 150; i++) begin
      pu = 1'($urandom_range(0, 1));
      pd = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) begin
        case ($urandom_range(0, 3))
          0: h = 12'($urandom_range(0, 15));
          1: h = 12'($urandom_range(625, 645));
          2: h = 12'($urandom_range(0, 4095));
          default: h = 12'($urandom_range(0, 639));
        endcase
        v = 12'($urandom_range(0, 600));
        @(negedge clk);
      end
    end

    pu = 1'b1;
    pd = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    h = 12'd635;
    v = 12'd240;
    pd = 1'b0;
    wait_ticks(6);
    chk_eq("pre_rst_speed", int'(s0), 3);
    chk_eq("pre_rst_y", int'(y0), 228);
    chk_eq("pre_rst_disp", int'(d1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_y", int'(y0), YRST);
    chk_eq("arst_speed", int'(s0), 1);
    chk_eq("arst_at_limit", int'(a1), 0);
    chk_eq("arst_disp", int'(d1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pd = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
